// File: rtl/ahb_s_mem.sv
// AHB-Lite slave memory: pipelined byte-lane read/write, two-cycle ERROR response for illegal accesses.
// Define AHB_S_WAIT_EN to insert WAIT_CYCLES wait states on every legal transfer.
module ahb_s_mem #(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int MEM_DEPTH_BYTES   = 1024,
    parameter int WAIT_CYCLES       = 1
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [AHB_DATA_WIDTH-1:0]    HRDATA
);

    localparam int NB        = AHB_DATA_WIDTH / 8;
    localparam int LB        = $clog2(NB);
    localparam int MEM_WORDS = MEM_DEPTH_BYTES / NB;
    localparam int WIDX      = $clog2(MEM_WORDS);
    localparam int AW1       = AHB_ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {OKAY_ST, WAIT_ST, ERR1_ST, ERR2_ST} state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_dp_valid;
    logic                      r_dp_write;
    logic [LB-1:0]             r_dp_lo;
    logic [2:0]                r_dp_size;
    logic [WIDX-1:0]           r_dp_idx;
    logic [AHB_DATA_WIDTH-1:0] r_mem [0:MEM_WORDS-1];

    logic                         w_xfer;
    logic                         w_illegal;
    logic                         w_legal_xfer;
    logic                         w_commit;
    logic [7:0]                   w_size_bytes;
    logic [AHB_ADDRESS_WIDTH-1:0] w_align_mask;
    logic [AW1-1:0]               w_end_addr;
    logic [NB-1:0]                w_dp_lanes;
    logic [AHB_DATA_WIDTH-1:0]    w_lane_mask;
    logic [AHB_DATA_WIDTH-1:0]    w_rd_word;
    logic                         w_unused;

`ifdef AHB_S_WAIT_EN
    logic [3:0] r_wcnt;
`else
    localparam int UNUSED_WAIT_CYCLES = WAIT_CYCLES;
`endif

    function automatic logic [NB-1:0] lane_en(input logic [LB-1:0] lo, input logic [2:0] sz);
        int nbytes;
        nbytes = 1 << sz;
        for (int i = 0; i < NB; i++) begin
            lane_en[i] = (i >= int'(lo)) && (i < int'(lo) + nbytes);
        end
    endfunction

    assign w_unused     = ^HBURST;
    assign w_xfer       = HTRANS[1];
    assign w_size_bytes = 8'd1 << HSIZE;
    assign w_align_mask = AHB_ADDRESS_WIDTH'(w_size_bytes) - AHB_ADDRESS_WIDTH'(1);
    assign w_end_addr   = {1'b0, HADDR} + AW1'(w_size_bytes);
    // Priority order only matters for reporting; any one failing makes the transfer illegal.
    assign w_illegal    = (int'(HSIZE) > LB) ||
                          ((HADDR & w_align_mask) != '0) ||
                          (w_end_addr > AW1'(MEM_DEPTH_BYTES));
    assign w_legal_xfer = HREADY && w_xfer && !w_illegal;

    always_comb begin
        w_next_state = r_state;
        HREADY       = 1'b1;
        HRESP        = 1'b0;
        case (r_state)
            OKAY_ST, ERR2_ST: begin
                HRESP = (r_state == ERR2_ST);
                if (w_xfer && w_illegal) begin
                    w_next_state = ERR1_ST;
`ifdef AHB_S_WAIT_EN
                end else if (w_xfer && (WAIT_CYCLES > 0)) begin
                    w_next_state = WAIT_ST;
`endif
                end else begin
                    w_next_state = OKAY_ST;
                end
            end
            WAIT_ST: begin
                HREADY = 1'b0;
`ifdef AHB_S_WAIT_EN
                if (r_wcnt == 4'd0) w_next_state = OKAY_ST;
`else
                w_next_state = OKAY_ST;
`endif
            end
            ERR1_ST: begin
                HREADY       = 1'b0;
                HRESP        = 1'b1;
                w_next_state = ERR2_ST;
            end
            default: w_next_state = OKAY_ST;
        endcase
    end

    // Data-phase registers load only when the bus is ready; errored transfers never become valid.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= OKAY_ST;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_lo    <= '0;
            r_dp_size  <= '0;
            r_dp_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (HREADY) begin
                r_dp_valid <= w_legal_xfer;
                if (w_xfer) begin
                    r_dp_write <= HWRITE;
                    r_dp_lo    <= HADDR[LB-1:0];
                    r_dp_size  <= HSIZE;
                    r_dp_idx   <= HADDR[LB +: WIDX];
                end
            end
        end
    end

`ifdef AHB_S_WAIT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wcnt <= 4'd0;
        end else if (w_legal_xfer) begin
            r_wcnt <= 4'(WAIT_CYCLES - 1);
        end else if ((r_state == WAIT_ST) && (r_wcnt != 4'd0)) begin
            r_wcnt <= r_wcnt - 4'd1;
        end
    end
`endif

    assign w_dp_lanes = lane_en(r_dp_lo, r_dp_size);
    assign w_commit   = HREADY && r_dp_valid && r_dp_write;
    assign w_rd_word  = r_mem[r_dp_idx];

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_lane_mask[8*i +: 8] = {8{w_dp_lanes[i]}};
        end
    end

    assign HRDATA = (r_dp_valid && !r_dp_write) ? (w_rd_word & w_lane_mask) : '0;

    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (w_dp_lanes[i]) r_mem[r_dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_s_mem.sv
// Directed bench for ahb_s_mem on a 64-bit bus, 1024-byte memory.
module tb_ahb_s_mem;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [63:0] HRDATA;

    int n_vec  = 0;
    int n_err  = 0;
    int n_wait = 0;
    int n_low  = 0;

    always #5 HCLK = ~HCLK;

    ahb_s_mem #(
        .AHB_DATA_WIDTH   (64),
        .AHB_ADDRESS_WIDTH(32),
        .MEM_DEPTH_BYTES  (1024),
        .WAIT_CYCLES      (2)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HSIZE  (HSIZE),
        .HBURST (HBURST),
        .HWDATA (HWDATA),
        .HREADY (HREADY),
        .HRESP  (HRESP),
        .HRDATA (HRDATA)
    );

    always @(negedge HCLK) begin
        if (HRESETn && !HREADY) n_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic w, input logic [2:0] s,
                         input logic [31:0] a, input logic [63:0] d);
        @(posedge HCLK);
        #1;
        HTRANS = t;
        HWRITE = w;
        HSIZE  = s;
        HADDR  = a;
        HWDATA = d;
        HBURST = (t == IDLE) ? 3'b000 : 3'b001;
        @(negedge HCLK);
    endtask

    task automatic cyc(input logic [1:0] t, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [63:0] d);
        drive(t, w, s, a, d);
        n_wait = 0;
        while (!HREADY && n_wait < 32) begin
            @(posedge HCLK);
            @(negedge HCLK);
            n_wait++;
        end
        if (!HREADY) chk_val("ready_timeout", 64'(HREADY), 64'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
        cyc(NSEQ, 1'b1, s, a, 64'd0);
        cyc(IDLE, 1'b0, 3'd0, 32'd0, d);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [2:0] s,
                            input logic [63:0] exp);
        cyc(NSEQ, 1'b0, s, a, 64'd0);
        cyc(IDLE, 1'b0, 3'd0, 32'd0, 64'd0);
        chk_val(tag, HRDATA, exp);
    endtask

    task automatic err_seq(input string tag, input logic w, input logic [2:0] s, input logic [31:0] a);
        cyc(NSEQ, w, s, a, 64'd0);
        drive(IDLE, 1'b0, 3'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_val({tag, "_err1"}, 64'({HREADY, HRESP}), 64'b01);
        chk_val({tag, "_err1_rdata"}, HRDATA, 64'd0);
        drive(IDLE, 1'b0, 3'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_val({tag, "_err2"}, 64'({HREADY, HRESP}), 64'b11);
        drive(IDLE, 1'b0, 3'd0, 32'd0, 64'd0);
        chk_val({tag, "_after"}, 64'({HREADY, HRESP}), 64'b10);
    endtask

    initial begin
        logic [7:0]  exp_b [8];
        logic [63:0] wd;
        logic [31:0] val;
        int          lows0;

        HRESETn = 1'b0;
        HTRANS  = IDLE;
        HWRITE  = 1'b0;
        HSIZE   = 3'd0;
        HADDR   = 32'd0;
        HBURST  = 3'd0;
        HWDATA  = 64'd0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk_val("rst_hready", 64'(HREADY), 64'd1);
        chk_val("rst_hresp", 64'(HRESP), 64'd0);
        chk_val("rst_hrdata", HRDATA, 64'd0);
        @(posedge HCLK);
        #2 HRESETn = 1'b1;

        // single word write into the upper lanes, then masked reads
        lows0 = n_low;
        wr(32'h10, 3'd3, 64'hAAAA_AAAA_5555_5555);
        wr(32'h14, 3'd2, 64'hDEAD_BEEF_0000_0000);
        rd_check("rd_w14", 32'h14, 3'd2, 64'hDEAD_BEEF_0000_0000);
        chk_val("rd_w14_hresp", 64'(HRESP), 64'd0);
        rd_check("rd_w10", 32'h10, 3'd2, 64'h0000_0000_5555_5555);
        rd_check("rd_d10", 32'h10, 3'd3, 64'hDEAD_BEEF_5555_5555);
`ifndef AHB_S_WAIT_EN
        chk_val("single_hready_low", 64'(n_low - lows0), 64'd0);
`endif

        // INCR4 halfword writes, read pipelined right behind the last beat, then INCR8 byte reads
        exp_b = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        cyc(NSEQ, 1'b1, 3'd1, 32'h20, 64'd0);
        cyc(SEQ,  1'b1, 3'd1, 32'h22, 64'h0000_0000_0000_1111);
        cyc(SEQ,  1'b1, 3'd1, 32'h24, 64'h0000_0000_2222_0000);
        cyc(SEQ,  1'b1, 3'd1, 32'h26, 64'h0000_3333_0000_0000);
        cyc(NSEQ, 1'b0, 3'd0, 32'h26, 64'h4444_0000_0000_0000);
        cyc(NSEQ, 1'b0, 3'd0, 32'h20, 64'd0);
        chk_val("raw_b26", HRDATA, 64'h0044_0000_0000_0000);
        for (int k = 1; k < 8; k++) begin
            cyc(SEQ, 1'b0, 3'd0, 32'(32'h20 + k), 64'd0);
            chk_val($sformatf("incr8_b%0d", k - 1), HRDATA, 64'(exp_b[k-1]) << (8 * (k - 1)));
        end
        cyc(IDLE, 1'b0, 3'd0, 32'd0, 64'd0);
        chk_val("incr8_b7", HRDATA, 64'(exp_b[7]) << 56);

        // INCR8 word write with a BUSY cycle after beat 3; garbage on HWDATA after BUSY must not land
        lows0 = n_low;
        wd    = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                cyc(BUSY, 1'b1, 3'd2, 32'h8C, wd);
                wd = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            cyc((k == 0) ? NSEQ : SEQ, 1'b1, 3'd2, 32'(32'h80 + 4 * k), wd);
            val = 32'hC0DE_0000 + 32'(k);
            wd  = 64'(val) << (32 * (k % 2));
        end
        cyc(IDLE, 1'b0, 3'd0, 32'd0, wd);
`ifndef AHB_S_WAIT_EN
        chk_val("busy_hready_low", 64'(n_low - lows0), 64'd0);
`endif
        for (int k = 0; k < 8; k++) begin
            val = 32'hC0DE_0000 + 32'(k);
            rd_check($sformatf("incr8_w%0d", k), 32'(32'h80 + 4 * k), 3'd2, 64'(val) << (32 * (k % 2)));
        end

        // illegal accesses: out of range, misaligned, oversize
        wr(32'h00, 3'd3, 64'h0123_4567_89AB_CDEF);
        err_seq("oob_rd400", 1'b0, 3'd2, 32'h400);
        err_seq("misal_wr02", 1'b1, 3'd2, 32'h02);
        err_seq("size16_rd00", 1'b0, 3'd4, 32'h00);
        rd_check("err_mem_unchanged", 32'h00, 3'd3, 64'h0123_4567_89AB_CDEF);

        // reset asserted during the second beat of an INCR4 write
        wr(32'h60, 3'd3, 64'hA5A5_A5A5_A5A5_A5A5);
        wr(32'h68, 3'd3, 64'hA5A5_A5A5_A5A5_A5A5);
        cyc(NSEQ, 1'b1, 3'd2, 32'h60, 64'd0);
        cyc(SEQ,  1'b1, 3'd2, 32'h64, 64'h0000_0000_1111_1111);
        cyc(SEQ,  1'b1, 3'd2, 32'h68, 64'h2222_2222_0000_0000);
        #1;
        HRESETn = 1'b0;
        HTRANS  = IDLE;
        #1;
        chk_val("midrst_hready", 64'(HREADY), 64'd1);
        chk_val("midrst_hresp", 64'(HRESP), 64'd0);
        chk_val("midrst_hrdata", HRDATA, 64'd0);
        @(posedge HCLK);
        @(posedge HCLK);
        #2 HRESETn = 1'b1;
        rd_check("midrst_d60", 32'h60, 3'd3, 64'hA5A5_A5A5_1111_1111);
        rd_check("midrst_d68", 32'h68, 3'd3, 64'hA5A5_A5A5_A5A5_A5A5);

`ifdef AHB_S_WAIT_EN
        // two wait states per beat on an INCR4 word write
        cyc(NSEQ, 1'b1, 3'd2, 32'h40, 64'd0);
        for (int k = 0; k < 4; k++) begin
            val = 32'h4000_0000 + 32'(k);
            cyc((k < 3) ? SEQ : IDLE, (k < 3), 3'd2, 32'(32'h44 + 4 * k), 64'(val) << (32 * (k % 2)));
            chk_val($sformatf("wait_beat%0d", k), 64'(n_wait), 64'd2);
        end
        for (int k = 0; k < 4; k++) begin
            val = 32'h4000_0000 + 32'(k);
            rd_check($sformatf("wait_rd%0d", k), 32'(32'h40 + 4 * k), 3'd2, 64'(val) << (32 * (k % 2)));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
